// File: rtl/ddr_rd_stream.sv
// DDR read-back streamer: fetches a contiguous DDR region over the AXI read channel
// and presents the 256-bit beats on a first-word-fall-through valid/ready stream.
module ddr_rd_stream #(
    parameter int BURST_LEN  = 8,
    parameter int FIFO_DEPTH = 16
) (
    input  logic         ddr_clk,
    input  logic         ddr_rst,
    input  logic [31:0]  rd_mode,
    input  logic [31:0]  rd_baseaddr,
    input  logic [31:0]  rd_len,
    input  logic         abort,
    output logic [27:0]  ddr_axi_araddr,
    output logic [3:0]   ddr_axi_aruser_id,
    output logic [3:0]   ddr_axi_arlen,
    output logic         ddr_axi_arvalid,
    input  logic         ddr_axi_arready,
    input  logic [255:0] ddr_axi_rdata,
    input  logic         ddr_axi_rlast,
    input  logic         ddr_axi_rvalid,
    output logic         out_valid,
    output logic [255:0] out_data,
    input  logic         out_ready,
    output logic         busy,
    output logic         done,
    output logic         rlast_err
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int OW = AW + 1;
    localparam int CW = AW + 3;
    localparam logic [31:0] MODE_START = 32'h0000_0020;

    typedef enum logic [2:0] {IDLE, REQ, DRAIN, FLUSH, DONE} state_t;

    state_t         state, state_nxt;
    logic [31:0]    rd_mode_q;
    logic           start, start_acc;
    logic [27:0]    addr;
    logic [26:0]    rem;
    logic [4:0]     burst_n;
    logic [4:0]     ar_beats;
    logic [CW-1:0]  credit_sum;
    logic           ar_issue, ar_hs;
    logic [OW-1:0]  out_cnt, fcnt;
    logic [AW-1:0]  wr_ptr, rd_ptr, lq_wr, lq_rd;
    logic [255:0]   mem [FIFO_DEPTH];
    logic [3:0]     lq_mem [FIFO_DEPTH];
    logic [3:0]     bcnt;
    logic           exp_last, wr_en, rd_en;
    logic           unused_bits;

    assign unused_bits = ^{rd_baseaddr[31:28], rd_len[4:0]};

    assign start     = (rd_mode == MODE_START) && (rd_mode_q != MODE_START);
    assign start_acc = start && (state == IDLE);

    assign burst_n    = (rem < 27'(BURST_LEN)) ? rem[4:0] : 5'(BURST_LEN);
    assign ar_beats   = 5'(ddr_axi_arlen) + 5'd1;
    assign credit_sum = CW'(fcnt) + CW'(out_cnt) + CW'(burst_n);
    // A burst is only requested when every beat it returns is guaranteed a FIFO slot.
    assign ar_issue   = (state == REQ) && !abort && !ddr_axi_arvalid && (rem != '0)
                        && (credit_sum <= CW'(FIFO_DEPTH));
    assign ar_hs      = ddr_axi_arvalid && ddr_axi_arready;

    assign ddr_axi_aruser_id = 4'h1;

    assign wr_en     = ddr_axi_rvalid && (state != FLUSH);
    assign out_valid = (fcnt != '0) && (state != FLUSH);
    assign rd_en     = out_valid && out_ready;
    assign out_data  = out_valid ? mem[rd_ptr] : '0;
    assign exp_last  = (bcnt == lq_mem[lq_rd]);

    always_ff @(posedge ddr_clk) begin
        if (ddr_rst) begin
            state     <= IDLE;
            rd_mode_q <= '0;
        end else begin
            state     <= state_nxt;
            rd_mode_q <= rd_mode;
        end
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) state_nxt = (rd_len[31:5] == '0) ? DONE : REQ;
            end
            REQ: begin
                busy = 1'b1;
                if (abort) state_nxt = FLUSH;
                else if ((rem == '0) && !ddr_axi_arvalid) state_nxt = DRAIN;
            end
            DRAIN: begin
                busy = 1'b1;
                if (abort) state_nxt = FLUSH;
                else if ((out_cnt == '0) && (fcnt == '0)) state_nxt = DONE;
            end
            FLUSH: begin
                busy = 1'b1;
                if ((out_cnt == '0) && !ddr_axi_arvalid) state_nxt = IDLE;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // AR request generation; a raised arvalid is held through abort until accepted.
    always_ff @(posedge ddr_clk) begin
        if (ddr_rst) begin
            addr            <= '0;
            rem             <= '0;
            ddr_axi_araddr  <= '0;
            ddr_axi_arlen   <= '0;
            ddr_axi_arvalid <= 1'b0;
            out_cnt         <= '0;
        end else begin
            if (start_acc) begin
                addr <= rd_baseaddr[27:0];
                rem  <= rd_len[31:5];
            end else if (ar_hs) begin
                addr <= addr + 28'({ar_beats, 5'b0});
                rem  <= rem - 27'(ar_beats);
            end
            if (ar_hs) begin
                ddr_axi_arvalid <= 1'b0;
            end else if (ar_issue) begin
                ddr_axi_arvalid <= 1'b1;
                ddr_axi_araddr  <= addr;
                ddr_axi_arlen   <= 4'(burst_n - 5'd1);
            end
            out_cnt <= out_cnt + (ar_hs ? OW'(ar_beats) : '0) - OW'(ddr_axi_rvalid);
        end
    end

    // R path: burst lengths queue in issue order so each beat knows where rlast belongs.
    always_ff @(posedge ddr_clk) begin
        if (ddr_rst) begin
            lq_wr     <= '0;
            lq_rd     <= '0;
            bcnt      <= '0;
            rlast_err <= 1'b0;
        end else begin
            if (ar_hs) lq_wr <= lq_wr + 1'b1;
            if (ddr_axi_rvalid) begin
                if (exp_last) begin
                    bcnt  <= '0;
                    lq_rd <= lq_rd + 1'b1;
                end else begin
                    bcnt <= bcnt + 4'd1;
                end
            end
            if (start_acc) rlast_err <= 1'b0;
            else if (ddr_axi_rvalid && (ddr_axi_rlast != exp_last)) rlast_err <= 1'b1;
        end
    end

    always_ff @(posedge ddr_clk) begin
        if (ar_hs) lq_mem[lq_wr] <= ddr_axi_arlen;
        if (wr_en) mem[wr_ptr] <= ddr_axi_rdata;
    end

    always_ff @(posedge ddr_clk) begin
        if (ddr_rst || (state == FLUSH)) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            fcnt   <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (rd_en) rd_ptr <= rd_ptr + 1'b1;
            fcnt <= fcnt + OW'(wr_en) - OW'(rd_en);
        end
    end

endmodule

// File: tb/tb_ddr_rd_stream.sv
// Directed bench for ddr_rd_stream with a small AXI read-slave model and stream consumer.
module tb_ddr_rd_stream;

    logic         clk = 1'b0;
    logic         rst;
    logic [31:0]  rd_mode, rd_baseaddr, rd_len;
    logic         abort;
    logic [27:0]  araddr;
    logic [3:0]   aruser_id, arlen;
    logic         arvalid, arready;
    logic [255:0] rdata;
    logic         rlast, rvalid;
    logic         out_valid;
    logic [255:0] out_data;
    logic         out_ready;
    logic         busy, done, rlast_err;

    always #5 clk = ~clk;

    ddr_rd_stream dut (
        .ddr_clk           (clk),
        .ddr_rst           (rst),
        .rd_mode           (rd_mode),
        .rd_baseaddr       (rd_baseaddr),
        .rd_len            (rd_len),
        .abort             (abort),
        .ddr_axi_araddr    (araddr),
        .ddr_axi_aruser_id (aruser_id),
        .ddr_axi_arlen     (arlen),
        .ddr_axi_arvalid   (arvalid),
        .ddr_axi_arready   (arready),
        .ddr_axi_rdata     (rdata),
        .ddr_axi_rlast     (rlast),
        .ddr_axi_rvalid    (rvalid),
        .out_valid         (out_valid),
        .out_data          (out_data),
        .out_ready         (out_ready),
        .busy              (busy),
        .done              (done),
        .rlast_err         (rlast_err)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [255:0] mk_word(input logic [27:0] a);
        return {8{4'hA, a}};
    endfunction

    logic [27:0] rq_addr[$];
    int          rq_len[$];
    logic [27:0] ar_log_addr[$];
    int          ar_log_len[$];
    int          cur_beat = 0;
    int          r_budget = -1;
    int          inj_beat = -1;
    int          ar_delay = 0;
    int          ar_wait = 0;
    int          ar_stall = 0;
    int          beats_sent = 0;
    int          done_cnt = 0;
    int          word_cnt = 0;
    logic [27:0] exp_base = '0;
    logic [27:0] ar_first_addr = '0;
    logic [3:0]  ar_first_len = '0;

    // Slave model and consumer run on the falling edge; the DUT samples on the rising edge.
    always @(negedge clk) begin
        if (rst) begin
            arready  = 1'b0;
            rvalid   = 1'b0;
            rlast    = 1'b0;
            rdata    = '0;
            cur_beat = 0;
            ar_wait  = 0;
            rq_addr.delete();
            rq_len.delete();
        end else begin
            rvalid = 1'b0;
            rlast  = 1'b0;
            if (rq_addr.size() > 0 && r_budget != 0) begin
                rvalid = 1'b1;
                rdata  = mk_word(rq_addr[0] + 28'(cur_beat * 32));
                rlast  = (cur_beat == rq_len[0]) || (cur_beat == inj_beat);
                beats_sent++;
                if (r_budget > 0) r_budget--;
                if (cur_beat == rq_len[0]) begin
                    cur_beat = 0;
                    void'(rq_addr.pop_front());
                    void'(rq_len.pop_front());
                    inj_beat = -1;
                end else begin
                    cur_beat++;
                end
            end
            if (arready) begin
                arready = 1'b0;
            end else if (arvalid) begin
                if (ar_wait == 0) begin
                    ar_first_addr = araddr;
                    ar_first_len  = arlen;
                end else begin
                    check_eq("ar_hold_addr", araddr, ar_first_addr);
                    check_eq("ar_hold_len", arlen, ar_first_len);
                end
                if (ar_wait == ar_delay) begin
                    arready = 1'b1;
                    ar_wait = 0;
                    rq_addr.push_back(araddr);
                    rq_len.push_back(int'(arlen));
                    ar_log_addr.push_back(araddr);
                    ar_log_len.push_back(int'(arlen));
                end else begin
                    ar_wait++;
                    ar_stall++;
                end
            end
            if (done) done_cnt++;
            if (out_valid && out_ready) begin
                check_eq("out_data", out_data, mk_word(exp_base + 28'(word_cnt * 32)));
                word_cnt++;
            end
        end
    end

    task automatic start_xfer(input logic [27:0] base, input logic [31:0] len);
        ar_log_addr.delete();
        ar_log_len.delete();
        done_cnt = 0;
        word_cnt = 0;
        ar_stall = 0;
        exp_base = base;
        rd_mode  = 32'h0;
        @(posedge clk); #1;
        rd_baseaddr = {4'h0, base};
        rd_len      = len;
        rd_mode     = 32'h0000_0020;
        @(posedge clk); #1;
    endtask

    task automatic wait_idle(input int budget);
        for (int i = 0; i < budget && busy; i++) begin
            @(posedge clk); #1;
        end
        check_eq("idle_reached", busy, 0);
        repeat (3) @(posedge clk);
        #1;
    endtask

    logic [27:0] t2_addr [3] = '{28'h000, 28'h100, 28'h200};
    int          t2_len  [3] = '{7, 7, 4};
    int          b0;

    initial begin
        rst = 1'b1; rd_mode = '0; rd_baseaddr = '0; rd_len = '0; abort = 1'b0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;
        check_eq("rst_arvalid", arvalid, 0);
        check_eq("rst_araddr", araddr, 0);
        check_eq("rst_arlen", arlen, 0);
        check_eq("rst_aruser", aruser_id, 4'h1);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_out_valid", out_valid, 0);
        check_eq("rst_rlast_err", rlast_err, 0);

        // single burst
        out_ready = 1'b1;
        start_xfer(28'h100, 32'd256);
        check_eq("t1_busy", busy, 1);
        wait_idle(500);
        check_eq("t1_nar", ar_log_addr.size(), 1);
        check_eq("t1_addr", ar_log_addr[0], 28'h100);
        check_eq("t1_len", ar_log_len[0], 7);
        check_eq("t1_words", word_cnt, 8);
        check_eq("t1_done", done_cnt, 1);
        check_eq("t1_err", rlast_err, 0);

        // 21 beats: two full bursts and a 5-beat tail
        start_xfer(28'h0, 32'h2A0);
        wait_idle(500);
        check_eq("t2_nar", ar_log_addr.size(), 3);
        for (int i = 0; i < 3; i++) begin
            check_eq("t2_addr", ar_log_addr[i], t2_addr[i]);
            check_eq("t2_len", ar_log_len[i], t2_len[i]);
        end
        check_eq("t2_words", word_cnt, 21);
        check_eq("t2_done", done_cnt, 1);

        // credit limit with a stalled consumer
        out_ready = 1'b0;
        start_xfer(28'h1000, 32'd1024);
        repeat (60) @(posedge clk);
        #1;
        check_eq("t3_nar_stall", ar_log_addr.size(), 2);
        check_eq("t3_ov", out_valid, 1);
        check_eq("t3_busy", busy, 1);
        out_ready = 1'b1;
        repeat (7) @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check_eq("t3_nar_7pop", ar_log_addr.size(), 2);
        check_eq("t3_words_7", word_cnt, 7);
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check_eq("t3_nar_8pop", ar_log_addr.size(), 3);
        out_ready = 1'b1;
        wait_idle(1000);
        check_eq("t3_nar", ar_log_addr.size(), 4);
        check_eq("t3_words", word_cnt, 32);
        check_eq("t3_done", done_cnt, 1);

        // arready held off 5 cycles
        ar_delay = 5;
        start_xfer(28'h2000, 32'd256);
        wait_idle(500);
        ar_delay = 0;
        check_eq("t4_stall", ar_stall, 5);
        check_eq("t4_nar", ar_log_addr.size(), 1);
        check_eq("t4_addr", ar_log_addr[0], 28'h2000);
        check_eq("t4_words", word_cnt, 8);
        check_eq("t4_done", done_cnt, 1);

        // abort with 3 of 8 beats returned
        out_ready = 1'b0;
        r_budget  = 3;
        b0        = beats_sent;
        start_xfer(28'h3000, 32'd256);
        for (int i = 0; i < 100 && (beats_sent - b0) < 3; i++) begin
            @(posedge clk); #1;
        end
        repeat (2) @(posedge clk);
        #1;
        check_eq("t5_beats_pre", beats_sent - b0, 3);
        check_eq("t5_ov_pre", out_valid, 1);
        abort = 1'b1;
        @(posedge clk);
        #1 abort = 1'b0;
        check_eq("t5_ov_flush", out_valid, 0);
        check_eq("t5_busy_flush", busy, 1);
        r_budget = -1;
        wait_idle(500);
        check_eq("t5_done", done_cnt, 0);
        check_eq("t5_words", word_cnt, 0);
        check_eq("t5_ov_post", out_valid, 0);
        check_eq("t5_beats", beats_sent - b0, 8);
        out_ready = 1'b1;
        start_xfer(28'h100, 32'd64);
        wait_idle(500);
        check_eq("t5b_words", word_cnt, 2);
        check_eq("t5b_done", done_cnt, 1);

        // early rlast on beat 4
        inj_beat = 3;
        start_xfer(28'h4000, 32'd256);
        wait_idle(500);
        check_eq("t6_err", rlast_err, 1);
        check_eq("t6_done", done_cnt, 1);
        check_eq("t6_words", word_cnt, 8);
        start_xfer(28'h4100, 32'd256);
        check_eq("t6_err_clr", rlast_err, 0);
        wait_idle(500);
        check_eq("t6_err_after", rlast_err, 0);
        check_eq("t6b_done", done_cnt, 1);

        // length below one beat
        start_xfer(28'h500, 32'h1F);
        check_eq("t7_busy", busy, 0);
        wait_idle(50);
        check_eq("t7_nar", ar_log_addr.size(), 0);
        check_eq("t7_done", done_cnt, 1);
        check_eq("t7_words", word_cnt, 0);

        // address wraps at 2^28
        start_xfer(28'hFFFFF00, 32'd512);
        wait_idle(500);
        check_eq("t8_nar", ar_log_addr.size(), 2);
        check_eq("t8_addr0", ar_log_addr[0], 28'hFFFFF00);
        check_eq("t8_addr1", ar_log_addr[1], 28'h0000000);
        check_eq("t8_words", word_cnt, 16);
        check_eq("t8_done", done_cnt, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
